// File: rtl/fc_weight_mem_ctrl_pkg.sv
// Shared definitions for the SE-block weight memory segment sequencers:
// FSM state encoding and default geometry of the memory segments.
package fc_weight_mem_ctrl_pkg;

   localparam int HEIGHT_DEF  = 32;
   localparam int BITSIZE_DEF = 14;
   localparam int AW_DEF      = 15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READ  = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

endpackage

// File: rtl/fc_weight_mem_ctrl.sv
// Sequencer sharing a 1-port weight memory between a loader write burst and
// an FC compute read burst streamed out with valid/ready backpressure.
module fc_weight_mem_ctrl
   import fc_weight_mem_ctrl_pkg::*;
#(
   parameter int HEIGHT  = HEIGHT_DEF,
   parameter int BITSIZE = BITSIZE_DEF,
   parameter int AW      = AW_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ld_start,
   input  logic [AW-1:0]      ld_base,
   input  logic [AW-1:0]      ld_len,
   input  logic               ld_valid,
   input  logic [BITSIZE-1:0] ld_data,
   output logic               ld_ready,
   input  logic               rd_start,
   input  logic [AW-1:0]      rd_base,
   input  logic [AW-1:0]      rd_len,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BITSIZE-1:0] out_data,
   output logic               out_last,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic               mem_en,
   output logic               mem_rd,
   output logic               mem_wr,
   output logic [AW-1:0]      mem_index,
   output logic [BITSIZE-1:0] mem_wdata,
   input  logic [BITSIZE-1:0] mem_rdata
);

   localparam logic [AW:0]   DEPTH = (AW+1)'(HEIGHT);
   localparam logic [AW-1:0] ONE   = AW'(1);

   state_e        state_q, state_d;
   logic [AW-1:0] base_q, base_d;
   logic [AW-1:0] len_q, len_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          ov_q, ov_d;
   logic          last_q, last_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic [AW:0]   ld_end, rd_end;
   logic          ld_bad, rd_bad;
   logic [AW-1:0] addr;
   logic          cnt_last;

   // One extra bit on the end address so base+len cannot wrap past the check
   assign ld_end   = {1'b0, ld_base} + {1'b0, ld_len};
   assign rd_end   = {1'b0, rd_base} + {1'b0, rd_len};
   assign ld_bad   = (ld_len == '0) || (ld_end > DEPTH);
   assign rd_bad   = (rd_len == '0) || (rd_end > DEPTH);
   assign addr     = base_q + cnt_q;
   assign cnt_last = (cnt_q == (len_q - ONE));

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      ov_d      = ov_q;
      last_d    = last_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      ld_ready  = 1'b0;
      mem_en    = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_index = '0;
      mem_wdata = '0;
      case (state_q)
         ST_IDLE: begin
            if (ld_start) begin
               if (ld_bad) begin
                  err_d = 1'b1;
               end else begin
                  state_d = ST_LOAD;
                  base_d  = ld_base;
                  len_d   = ld_len;
                  cnt_d   = '0;
               end
            end else if (rd_start) begin
               if (rd_bad) begin
                  err_d = 1'b1;
               end else begin
                  state_d = ST_READ;
                  base_d  = rd_base;
                  len_d   = rd_len;
                  cnt_d   = '0;
               end
            end
         end
         ST_LOAD: begin
            ld_ready = 1'b1;
            if (ld_valid) begin
               mem_en    = 1'b1;
               mem_wr    = 1'b1;
               mem_index = addr;
               mem_wdata = ld_data;
               cnt_d     = cnt_q + ONE;
               if (cnt_last) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         ST_READ: begin
            // Issue only when the output slot is free or drains this cycle,
            // so the memory's held read data is never overwritten unseen
            if (!ov_q || out_ready) begin
               mem_en    = 1'b1;
               mem_rd    = 1'b1;
               mem_index = addr;
               cnt_d     = cnt_q + ONE;
               ov_d      = 1'b1;
               last_d    = cnt_last;
               if (cnt_last) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (ov_q && out_ready) begin
               ov_d   = 1'b0;
               last_d = 1'b0;
               if (last_q) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         ov_q    <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         ov_q    <= ov_d;
         last_q  <= last_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign out_valid = ov_q;
   assign out_last  = last_q;
   assign out_data  = mem_rdata;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_fc_weight_mem_ctrl.sv
// Bench for fc_weight_mem_ctrl: drives load/read bursts against a 1-port memory
// model and checks the stream against a word-array reference of loaded data.
module tb_fc_weight_mem_ctrl;
   localparam int HEIGHT = 32, BITSIZE = 14, AW = 15;

   logic clk = 1'b0, rst;
   logic ld_start, ld_valid, ld_ready, rd_start, out_valid, out_ready, out_last;
   logic busy, done, err, mem_en, mem_rd, mem_wr;
   logic [AW-1:0] ld_base, ld_len, rd_base, rd_len, mem_index;
   logic [BITSIZE-1:0] ld_data, out_data, mem_wdata, mem_rdata;

   logic [BITSIZE-1:0] env_mem [0:HEIGHT-1];
   logic [BITSIZE-1:0] ref_mem [0:HEIGHT-1];
   logic [BITSIZE-1:0] stim    [0:HEIGHT-1];
   int vectors = 0, miscompares = 0;

   fc_weight_mem_ctrl dut (
      .clk(clk), .rst(rst),
      .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
      .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .done(done), .err(err),
      .mem_en(mem_en), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_index(mem_index), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Single-port memory: 1-cycle read latency, read data held between reads
   always @(posedge clk) begin
      if (mem_en && mem_wr) env_mem[mem_index[4:0]] <= mem_wdata;
      if (mem_en && mem_rd) mem_rdata <= env_mem[mem_index[4:0]];
   end

   task automatic check_all_zero(input string name);
      vectors++;
      if ({ld_ready, out_valid, out_last, busy, done, err, mem_en, mem_rd, mem_wr} !== 9'd0 ||
          mem_index !== '0 || mem_wdata !== '0) begin
         miscompares++;
         $display("FAIL %s: ctl=%b idx=%0d wdata=%0d, required all 0", name,
                  {ld_ready, out_valid, out_last, busy, done, err, mem_en, mem_rd, mem_wr},
                  mem_index, mem_wdata);
      end
   endtask

   task automatic run_load(input int base, input int len, input bit gaps, input bit also_rd);
      int k, cyc;
      @(negedge clk);
      ld_start = 1'b1; ld_base = AW'(base); ld_len = AW'(len);
      if (also_rd) begin rd_start = 1'b1; rd_base = '0; rd_len = AW'(1); end
      k = 0; cyc = 0;
      while (k < len && cyc < 200) begin
         @(negedge clk);
         ld_start = 1'b0;
         rd_start = 1'($urandom_range(0, 1)); rd_base = '0; rd_len = '0;
         ld_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         ld_data  = stim[k];
         #1;
         vectors++;
         if (ld_ready !== 1'b1 || busy !== 1'b1 || err !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL load_ctrl: ready=%b busy=%b err=%b done=%b, required 1 1 0 0",
                     ld_ready, busy, err, done);
         end
         vectors++;
         if (mem_wr !== ld_valid || mem_en !== ld_valid || mem_rd !== 1'b0) begin
            miscompares++;
            $display("FAIL load_strobe: en=%b wr=%b rd=%b, required en=wr=%b rd=0",
                     mem_en, mem_wr, mem_rd, ld_valid);
         end
         if (ld_valid) begin
            vectors++;
            if (mem_index !== AW'(base + k) || mem_wdata !== stim[k]) begin
               miscompares++;
               $display("FAIL load_word: idx=%0d data=%0d, required idx=%0d data=%0d",
                        mem_index, mem_wdata, base + k, stim[k]);
            end
            ref_mem[base + k] = stim[k];
            k++;
         end
         cyc++;
      end
      @(negedge clk);
      ld_valid = 1'b0; rd_start = 1'b0;
      #1;
      vectors++;
      if (k != len || done !== 1'b1 || busy !== 1'b0 || ld_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL load_done: words=%0d done=%b busy=%b ready=%b, required %0d 1 0 0",
                  k, done, busy, ld_ready, len);
      end
      @(negedge clk); #1;
      vectors++;
      if (done !== 1'b0) begin
         miscompares++;
         $display("FAIL load_done_pulse: done=%b, required 0", done);
      end
   endtask

   // mode 0: always ready, 1: random ready, 2: ready low 2 cycles on 2nd word
   task automatic run_read(input int base, input int len, input int mode);
      int j, cyc, issues, held;
      @(negedge clk);
      rd_start = 1'b1; rd_base = AW'(base); rd_len = AW'(len);
      j = 0; cyc = 0; issues = 0; held = 0;
      while (j < len && cyc < 300) begin
         @(negedge clk);
         rd_start = 1'b0;
         case (mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = !(out_valid && j == 1 && held < 2);
         endcase
         if (!out_ready && mode == 2) held++;
         #1;
         if (mem_rd === 1'b1) issues++;
         vectors++;
         if (mem_wr !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL read_ctrl: wr=%b busy=%b done=%b err=%b, required 0 1 0 0",
                     mem_wr, busy, done, err);
         end
         if (out_valid === 1'b1) begin
            vectors++;
            if (out_data !== ref_mem[base + j] || out_last !== (j == len - 1)) begin
               miscompares++;
               $display("FAIL read_word %0d: data=%0d last=%b, required data=%0d last=%b",
                        j, $signed(out_data), out_last, $signed(ref_mem[base + j]), (j == len - 1));
            end
            if (out_ready) j++;
         end
         cyc++;
      end
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      vectors++;
      if (j != len || done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || mem_rd !== 1'b0) begin
         miscompares++;
         $display("FAIL read_done: words=%0d done=%b valid=%b busy=%b rd=%b, required %0d 1 0 0 0",
                  j, done, out_valid, busy, mem_rd, len);
      end
      vectors++;
      if (issues != len) begin
         miscompares++;
         $display("FAIL read_issues: mem_rd count=%0d, required %0d", issues, len);
      end
      if (mode == 0) begin
         vectors++;
         if (cyc != len + 1) begin
            miscompares++;
            $display("FAIL read_throughput: cycles=%0d, required %0d", cyc, len + 1);
         end
      end
   endtask

   task automatic test_err(input int base, input int len, input bit is_ld);
      @(negedge clk);
      if (is_ld) begin ld_start = 1'b1; ld_base = AW'(base); ld_len = AW'(len); end
      else       begin rd_start = 1'b1; rd_base = AW'(base); rd_len = AW'(len); end
      #1;
      vectors++;
      if (mem_en !== 1'b0 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL err_same_cycle: en=%b err=%b, required 0 0", mem_en, err);
      end
      @(negedge clk);
      ld_start = 1'b0; rd_start = 1'b0;
      #1;
      vectors++;
      if (err !== 1'b1 || busy !== 1'b0 || mem_en !== 1'b0) begin
         miscompares++;
         $display("FAIL err_pulse base=%0d len=%0d: err=%b busy=%b en=%b, required 1 0 0",
                  base, len, err, busy, mem_en);
      end
      @(negedge clk); #1;
      vectors++;
      if (err !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0) begin
         miscompares++;
         $display("FAIL err_clear: err=%b busy=%b en=%b, required 0 0 0", err, busy, mem_en);
      end
   endtask

   task automatic test_reset;
      #1;
      check_all_zero("reset_state");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check_all_zero("reset_release");
   endtask

   task automatic test_load;
      stim[0] = BITSIZE'(10); stim[1] = BITSIZE'(-20); stim[2] = BITSIZE'(30);
      run_load(4, 3, 1'b0, 1'b0);
   endtask

   task automatic test_read;
      run_read(4, 3, 0);
   endtask

   task automatic test_backpressure;
      run_read(4, 3, 2);
   endtask

   task automatic test_errors;
      test_err(0, 0, 1'b0);
      test_err(30, 3, 1'b1);
      test_err(29, 4, 1'b0);
      test_err(5, 0, 1'b1);
   endtask

   task automatic test_priority;
      for (int i = 0; i < 5; i++) stim[i] = BITSIZE'($urandom);
      run_load(8, 5, 1'b1, 1'b1);
      run_read(8, 5, 1);
   endtask

   task automatic test_reset_mid_read;
      @(negedge clk);
      rd_start = 1'b1; rd_base = AW'(4); rd_len = AW'(3);
      @(negedge clk);
      rd_start = 1'b0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check_all_zero("reset_mid_read");
      @(negedge clk);
      rst = 1'b1; out_ready = 1'b0;
      #1;
      check_all_zero("reset_mid_read_release");
      run_read(4, 3, 0);
   endtask

   task automatic test_random;
      int base, len;
      for (int n = 0; n < 6; n++) begin
         base = $urandom_range(0, HEIGHT - 1);
         len  = $urandom_range(1, HEIGHT - base);
         for (int i = 0; i < len; i++) stim[i] = BITSIZE'($urandom);
         run_load(base, len, 1'b1, 1'b0);
         run_read(base, len, 1);
      end
      for (int i = 0; i < 3; i++) stim[i] = BITSIZE'($urandom);
      run_load(29, 3, 1'b0, 1'b0);
      run_read(29, 3, 0);
      for (int i = 0; i < HEIGHT; i++) stim[i] = BITSIZE'($urandom);
      run_load(0, HEIGHT, 1'b1, 1'b0);
      run_read(0, HEIGHT, 1);
      run_read(0, HEIGHT, 0);
   endtask

   initial begin
      rst = 1'b0;
      ld_start = 1'b0; ld_base = '0; ld_len = '0; ld_valid = 1'b0; ld_data = '0;
      rd_start = 1'b0; rd_base = '0; rd_len = '0; out_ready = 1'b0;
      test_reset();
      test_load();
      test_read();
      test_backpressure();
      test_errors();
      test_priority();
      test_reset_mid_read();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
